// File: rtl/psg_bus_writer_pkg.sv
// Shared definitions for the SN76489 bus writer and its receiver model:
// register index constants, FSM state encoding and byte formatting helpers.
package psg_bus_writer_pkg;

  localparam logic [2:0] REG_TONE0 = 3'b000;
  localparam logic [2:0] REG_ATTN0 = 3'b001;
  localparam logic [2:0] REG_TONE1 = 3'b010;
  localparam logic [2:0] REG_ATTN1 = 3'b011;
  localparam logic [2:0] REG_TONE2 = 3'b100;
  localparam logic [2:0] REG_ATTN2 = 3'b101;
  localparam logic [2:0] REG_NOISE = 3'b110;
  localparam logic [2:0] REG_ATTN3 = 3'b111;

  localparam int CMD_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP1,
    ST_DATA,
    ST_GAP2
  } psg_state_e;

  function automatic logic is_tone_reg(input logic [2:0] r);
    return (r[0] == 1'b0) && (r != REG_NOISE);
  endfunction

  // Noise control only has three meaningful bits; bit 3 of the byte is forced low.
  function automatic logic [7:0] latch_byte(input logic [2:0] r, input logic [3:0] lo);
    if (r == REG_NOISE)
      return {1'b1, REG_NOISE, 1'b0, lo[2:0]};
    return {1'b1, r, lo};
  endfunction

  function automatic logic [7:0] data_byte(input logic [5:0] hi);
    return {2'b00, hi};
  endfunction

endpackage

// File: rtl/psg_bus_writer_cmd_fifo.sv
// Show-ahead command queue; pointers carry one extra bit to tell full from empty.
module psg_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + PTR_ONE;
      if (pop && !empty)
        rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/psg_bus_writer.sv
// Queues PSG register writes and plays them out as timed byte strobes
// on the SN76489 data bus (latch byte, optional data byte for tones).
module psg_bus_writer
  import psg_bus_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WE_CYCLES  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_reg,
  input  logic [9:0] cmd_value,
  output logic [7:0] bus_data,
  output logic       bus_we_n,
  output logic       busy
);

  localparam int CNT_MAX = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WE_LOAD  = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  psg_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       data_d;
  logic             we_n_d;
  logic             tone_q, tone_d;
  logic [7:0]       hold_q, hold_d;
  logic             ready_en;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic [2:0]       head_reg;
  logic [9:0]       head_value;

  // Queue acceptance depends only on registered state, never on this cycle's pop.
  assign cmd_ready = ready_en && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign head_reg   = fifo_rdata[12:10];
  assign head_value = fifo_rdata[9:0];
  assign busy = !fifo_empty || (state != ST_IDLE);

  psg_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata({cmd_reg, cmd_value}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bus_data <= '0;
      bus_we_n <= 1'b1;
      tone_q   <= 1'b0;
      hold_q   <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bus_data <= data_d;
      bus_we_n <= we_n_d;
      tone_q   <= tone_d;
      hold_q   <= hold_d;
      ready_en <= 1'b1;
    end
  end

  // bus_data only moves together with a falling strobe, so it is stable across each gap.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    data_d   = bus_data;
    we_n_d   = bus_we_n;
    tone_d   = tone_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_LATCH;
          cnt_d    = WE_LOAD;
          we_n_d   = 1'b0;
          data_d   = latch_byte(head_reg, head_value[3:0]);
          tone_d   = is_tone_reg(head_reg);
          hold_d   = data_byte(head_value[9:4]);
        end
      end
      ST_LATCH, ST_DATA: begin
        if (cnt == '0) begin
          state_d = (state == ST_LATCH) ? ST_GAP1 : ST_GAP2;
          cnt_d   = GAP_LOAD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      ST_GAP1: begin
        if (cnt == '0) begin
          if (tone_q) begin
            state_d = ST_DATA;
            cnt_d   = WE_LOAD;
            we_n_d  = 1'b0;
            data_d  = hold_q;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      ST_GAP2: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        we_n_d  = 1'b1;
      end
    endcase
  end

endmodule
